// File: rtl/packet_switch_rx_dbg_csr.sv
// Per-RX-port debug register file: RX packet statistics with coherent 64-bit
// reads, saturating error/drop counters and a fixed one-cycle read return.
module packet_switch_rx_dbg_csr #(
  parameter int INST_ID    = 0,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] avmm_address_c1,
  input  logic                  avmm_read_c1,
  input  logic                  avmm_write_c1,
  input  logic [DATA_WIDTH-1:0] avmm_writedata_c1,
  input  logic [3:0]            avmm_byteenable_c1,
  output logic [DATA_WIDTH-1:0] avmm_readdata,
  output logic                  avmm_readdatavalid,
  input  logic                  rx_pkt_done,
  input  logic [LEN_WIDTH-1:0]  rx_pkt_len,
  input  logic                  rx_pkt_err,
  input  logic                  rx_pkt_drop
);

  typedef enum logic [3:0] {
    REG_CTRL    = 4'h0,
    REG_STATUS  = 4'h1,
    REG_PKT_LO  = 4'h2,
    REG_PKT_HI  = 4'h3,
    REG_BYTE_LO = 4'h4,
    REG_BYTE_HI = 4'h5,
    REG_ERR     = 4'h6,
    REG_DROP    = 4'h7,
    REG_MAX_LEN = 4'h8,
    REG_MIN_LEN = 4'h9,
    REG_SCRATCH = 4'hA,
    REG_ID      = 4'hB
  } reg_idx_e;

  localparam logic [31:0]          ID_VALUE = 32'hD8C0_0000 | 32'(INST_ID & 255);
  localparam logic [LEN_WIDTH-1:0] LEN_ONES = {LEN_WIDTH{1'b1}};

  reg_idx_e reg_idx;
  logic     unused_addr_bits;

  logic                 cnt_en,   cnt_en_nxt;
  logic [63:0]          pkt_cnt,  pkt_cnt_nxt;
  logic [63:0]          byte_cnt, byte_cnt_nxt;
  logic [31:0]          err_cnt,  err_cnt_nxt;
  logic [31:0]          drop_cnt, drop_cnt_nxt;
  logic                 err_sat,  err_sat_nxt;
  logic                 drop_sat, drop_sat_nxt;
  logic [LEN_WIDTH-1:0] max_len,  max_len_nxt;
  logic [LEN_WIDTH-1:0] min_len,  min_len_nxt;
  logic [31:0]          pkt_hi_shadow,  pkt_hi_shadow_nxt;
  logic [31:0]          byte_hi_shadow, byte_hi_shadow_nxt;
  logic [31:0]          scratch,  scratch_nxt;
  logic                 clr;
  logic [31:0]          rd_data;

  assign reg_idx          = reg_idx_e'(avmm_address_c1[5:2]);
  assign unused_addr_bits = ^{avmm_address_c1[ADDR_WIDTH-1:6], avmm_address_c1[1:0]};

  // Read mux sees only current register values, so reads always return pre-update data.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_CTRL:    rd_data = {31'b0, cnt_en};
      REG_STATUS:  rd_data = {30'b0, drop_sat, err_sat};
      REG_PKT_LO:  rd_data = pkt_cnt[31:0];
      REG_PKT_HI:  rd_data = pkt_hi_shadow;
      REG_BYTE_LO: rd_data = byte_cnt[31:0];
      REG_BYTE_HI: rd_data = byte_hi_shadow;
      REG_ERR:     rd_data = err_cnt;
      REG_DROP:    rd_data = drop_cnt;
      REG_MAX_LEN: rd_data = 32'(max_len);
      REG_MIN_LEN: rd_data = 32'(min_len);
      REG_SCRATCH: rd_data = scratch;
      REG_ID:      rd_data = ID_VALUE;
      default:     rd_data = '0;
    endcase
  end

  // NOTE: every variable gets a default before any branch; a path that leaves one unassigned infers a latch.
  always_comb begin
    cnt_en_nxt         = cnt_en;
    pkt_cnt_nxt        = pkt_cnt;
    byte_cnt_nxt       = byte_cnt;
    err_cnt_nxt        = err_cnt;
    drop_cnt_nxt       = drop_cnt;
    err_sat_nxt        = err_sat;
    drop_sat_nxt       = drop_sat;
    max_len_nxt        = max_len;
    min_len_nxt        = min_len;
    pkt_hi_shadow_nxt  = pkt_hi_shadow;
    byte_hi_shadow_nxt = byte_hi_shadow;
    scratch_nxt        = scratch;
    clr                = 1'b0;

    if (avmm_read_c1 && reg_idx == REG_PKT_LO)  pkt_hi_shadow_nxt  = pkt_cnt[63:32];
    if (avmm_read_c1 && reg_idx == REG_BYTE_LO) byte_hi_shadow_nxt = byte_cnt[63:32];

    if (rx_pkt_done && cnt_en) begin
      pkt_cnt_nxt  = pkt_cnt + 64'd1;
      byte_cnt_nxt = byte_cnt + 64'(rx_pkt_len);
      if (rx_pkt_err) begin
        if (err_cnt != '1) err_cnt_nxt = err_cnt + 32'd1;
        if (err_cnt_nxt == '1) err_sat_nxt = 1'b1;
      end
      if (rx_pkt_drop) begin
        if (drop_cnt != '1) drop_cnt_nxt = drop_cnt + 32'd1;
        if (drop_cnt_nxt == '1) drop_sat_nxt = 1'b1;
      end
      if (rx_pkt_len > max_len) max_len_nxt = rx_pkt_len;
      if (rx_pkt_len < min_len) min_len_nxt = rx_pkt_len;
    end

    if (avmm_write_c1) begin
      if (reg_idx == REG_CTRL && avmm_byteenable_c1[0]) begin
        cnt_en_nxt = avmm_writedata_c1[0];
        clr        = avmm_writedata_c1[1];
      end
      if (reg_idx == REG_SCRATCH) begin
        for (int b = 0; b < 4; b++) begin
          if (avmm_byteenable_c1[b]) scratch_nxt[8*b +: 8] = avmm_writedata_c1[8*b +: 8];
        end
      end
    end

    // Clear wins over a same-cycle packet event and over shadow capture.
    if (clr) begin
      pkt_cnt_nxt        = '0;
      byte_cnt_nxt       = '0;
      err_cnt_nxt        = '0;
      drop_cnt_nxt       = '0;
      err_sat_nxt        = 1'b0;
      drop_sat_nxt       = 1'b0;
      max_len_nxt        = '0;
      min_len_nxt        = LEN_ONES;
      pkt_hi_shadow_nxt  = '0;
      byte_hi_shadow_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_en             <= 1'b1;
      pkt_cnt            <= '0;
      byte_cnt           <= '0;
      err_cnt            <= '0;
      drop_cnt           <= '0;
      err_sat            <= 1'b0;
      drop_sat           <= 1'b0;
      max_len            <= '0;
      min_len            <= LEN_ONES;
      pkt_hi_shadow      <= '0;
      byte_hi_shadow     <= '0;
      scratch            <= '0;
      avmm_readdatavalid <= 1'b0;
      avmm_readdata      <= '0;
    end else begin
      cnt_en             <= cnt_en_nxt;
      pkt_cnt            <= pkt_cnt_nxt;
      byte_cnt           <= byte_cnt_nxt;
      err_cnt            <= err_cnt_nxt;
      drop_cnt           <= drop_cnt_nxt;
      err_sat            <= err_sat_nxt;
      drop_sat           <= drop_sat_nxt;
      max_len            <= max_len_nxt;
      min_len            <= min_len_nxt;
      pkt_hi_shadow      <= pkt_hi_shadow_nxt;
      byte_hi_shadow     <= byte_hi_shadow_nxt;
      scratch            <= scratch_nxt;
      avmm_readdatavalid <= avmm_read_c1;
      avmm_readdata      <= avmm_read_c1 ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_packet_switch_rx_dbg_csr.sv
// Bench for packet_switch_rx_dbg_csr: directed register-map scenarios followed by
// random traffic, all compared every cycle against a register-level model.
module tb_packet_switch_rx_dbg_csr;

  localparam int INST_ID   = 1;
  localparam int LEN_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [7:0]           avmm_address_c1 = '0;
  logic                 avmm_read_c1 = 1'b0;
  logic                 avmm_write_c1 = 1'b0;
  logic [31:0]          avmm_writedata_c1 = '0;
  logic [3:0]           avmm_byteenable_c1 = '0;
  logic [31:0]          avmm_readdata;
  logic                 avmm_readdatavalid;
  logic                 rx_pkt_done = 1'b0;
  logic [LEN_WIDTH-1:0] rx_pkt_len = '0;
  logic                 rx_pkt_err = 1'b0;
  logic                 rx_pkt_drop = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  packet_switch_rx_dbg_csr #(
    .INST_ID(INST_ID), .ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .avmm_address_c1(avmm_address_c1), .avmm_read_c1(avmm_read_c1),
    .avmm_write_c1(avmm_write_c1), .avmm_writedata_c1(avmm_writedata_c1),
    .avmm_byteenable_c1(avmm_byteenable_c1),
    .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid),
    .rx_pkt_done(rx_pkt_done), .rx_pkt_len(rx_pkt_len),
    .rx_pkt_err(rx_pkt_err), .rx_pkt_drop(rx_pkt_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register-level model of the programmer-visible state.
  logic                 m_en;
  logic [63:0]          m_pkt, m_byte;
  logic [31:0]          m_err, m_drop, m_pkt_sh, m_byte_sh, m_scratch;
  logic                 m_esat, m_dsat;
  logic [LEN_WIDTH-1:0] m_max, m_min;
  logic                 exp_valid;
  logic [31:0]          exp_data;
  logic                 chk_data;

  task automatic model_clear();
    m_pkt = '0; m_byte = '0; m_err = '0; m_drop = '0;
    m_esat = 1'b0; m_dsat = 1'b0; m_max = '0; m_min = '1;
    m_pkt_sh = '0; m_byte_sh = '0;
  endtask

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0:  return {31'b0, m_en};
      1:  return {30'b0, m_dsat, m_esat};
      2:  return m_pkt[31:0];
      3:  return m_pkt_sh;
      4:  return m_byte[31:0];
      5:  return m_byte_sh;
      6:  return m_err;
      7:  return m_drop;
      8:  return 32'(m_max);
      9:  return 32'(m_min);
      10: return m_scratch;
      11: return 32'hD8C0_0000 + 32'(INST_ID);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    int   idx;
    logic clr;
    logic new_en;
    idx    = int'(avmm_address_c1[5:2]);
    clr    = 1'b0;
    new_en = m_en;
    if (rst) begin
      model_clear();
      m_en = 1'b1; m_scratch = '0;
      exp_valid = 1'b0; exp_data = '0; chk_data = 1'b1;
      return;
    end
    exp_valid = avmm_read_c1;
    exp_data  = avmm_read_c1 ? model_read(idx) : 32'h0;
    chk_data  = avmm_read_c1;
    if (avmm_read_c1 && idx == 2) m_pkt_sh  = m_pkt[63:32];
    if (avmm_read_c1 && idx == 4) m_byte_sh = m_byte[63:32];
    if (rx_pkt_done && m_en) begin
      m_pkt  = m_pkt + 1;
      m_byte = m_byte + 64'(rx_pkt_len);
      if (rx_pkt_err)  m_err  = (m_err  == 32'hFFFF_FFFF) ? m_err  : m_err + 1;
      if (rx_pkt_drop) m_drop = (m_drop == 32'hFFFF_FFFF) ? m_drop : m_drop + 1;
      if (m_err  == 32'hFFFF_FFFF) m_esat = 1'b1;
      if (m_drop == 32'hFFFF_FFFF) m_dsat = 1'b1;
      m_max = (rx_pkt_len > m_max) ? rx_pkt_len : m_max;
      m_min = (rx_pkt_len < m_min) ? rx_pkt_len : m_min;
    end
    if (avmm_write_c1 && idx == 0 && avmm_byteenable_c1[0]) begin
      new_en = avmm_writedata_c1[0];
      clr    = avmm_writedata_c1[1];
    end
    if (avmm_write_c1 && idx == 10) begin
      for (int b = 0; b < 4; b++)
        if (avmm_byteenable_c1[b]) m_scratch[8*b +: 8] = avmm_writedata_c1[8*b +: 8];
    end
    m_en = new_en;
    if (clr) model_clear();
  endtask

  // Single compare process: model advances on each edge, DUT outputs checked 1 ns later.
  always begin
    @(posedge clk);
    model_step();
    #1;
    check("readdatavalid", 64'(avmm_readdatavalid), 64'(exp_valid));
    if (chk_data) check("readdata", 64'(avmm_readdata), 64'(exp_data));
  end

  task automatic idle();
    avmm_read_c1 = 1'b0; avmm_write_c1 = 1'b0; rx_pkt_done = 1'b0;
    rx_pkt_err = 1'b0; rx_pkt_drop = 1'b0;
  endtask

  // All drive tasks start right after a falling edge and end on the next one.
  task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
    avmm_read_c1 = 1'b1; avmm_address_c1 = a;
    @(negedge clk);
    avmm_read_c1 = 1'b0;
    check("read_latency_valid", 64'(avmm_readdatavalid), 64'd1);
    d = avmm_readdata;
  endtask

  task automatic csr_write(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] be);
    avmm_write_c1 = 1'b1; avmm_address_c1 = a;
    avmm_writedata_c1 = wd; avmm_byteenable_c1 = be;
    @(negedge clk);
    avmm_write_c1 = 1'b0;
  endtask

  task automatic pkt(input logic [LEN_WIDTH-1:0] len, input logic err, input logic drop);
    rx_pkt_done = 1'b1; rx_pkt_len = len; rx_pkt_err = err; rx_pkt_drop = drop;
    @(negedge clk);
    idle();
  endtask

  initial begin
    logic [31:0] d;

    // Reset, with a read presented in the last reset cycle.
    repeat (3) @(negedge clk);
    avmm_read_c1 = 1'b1; avmm_address_c1 = 8'h2C;
    @(negedge clk);
    rst = 1'b0; avmm_read_c1 = 1'b0;
    check("rst_read_no_valid", 64'(avmm_readdatavalid), 64'd0);
    check("rst_readdata", 64'(avmm_readdata), 64'd0);
    @(negedge clk);
    check("idle_no_valid", 64'(avmm_readdatavalid), 64'd0);

    csr_read(8'h2C, d); check("id", 64'(d), 64'hD8C0_0001);
    check("valid_one_cycle", 64'(avmm_readdatavalid), 64'd1);
    @(negedge clk);
    check("valid_drops", 64'(avmm_readdatavalid), 64'd0);
    csr_read(8'h00, d); check("ctrl_reset", 64'(d), 64'h1);
    csr_read(8'h24, d); check("min_len_reset", 64'(d), 64'hFFFF);

    pkt(16'd64, 1'b0, 1'b0);
    pkt(16'd1518, 1'b0, 1'b0);
    pkt(16'd100, 1'b0, 1'b0);
    csr_read(8'h08, d); check("pkt_cnt_lo", 64'(d), 64'd3);
    csr_read(8'h10, d); check("byte_cnt_lo", 64'(d), 64'd1682);
    csr_read(8'h20, d); check("max_len", 64'(d), 64'd1518);
    csr_read(8'h24, d); check("min_len", 64'(d), 64'd64);
    csr_read(8'h0C, d); check("pkt_cnt_hi", 64'(d), 64'd0);

    // Backdoor preload of the byte counter, held across one edge so the register keeps it.
    force dut.byte_cnt = 64'h0000_0000_FFFF_FFF0;
    m_byte = 64'h0000_0000_FFFF_FFF0;
    @(negedge clk);
    release dut.byte_cnt;
    pkt(16'h20, 1'b0, 1'b0);
    csr_read(8'h10, d); check("byte_lo_carry", 64'(d), 64'h10);
    pkt(16'd5, 1'b0, 1'b0);
    csr_read(8'h14, d); check("byte_hi_shadow", 64'(d), 64'h1);
    csr_read(8'h10, d); check("byte_lo_after", 64'(d), 64'h15);

    force dut.err_cnt = 32'hFFFF_FFFE;
    m_err = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.err_cnt;
    repeat (3) pkt(16'd80, 1'b1, 1'b0);
    csr_read(8'h18, d); check("err_cnt_sat", 64'(d), 64'hFFFF_FFFF);
    csr_read(8'h04, d); check("status_err_sat", 64'(d), 64'h1);

    // CLR together with a packet: the packet is lost.
    rx_pkt_done = 1'b1; rx_pkt_len = 16'd300;
    csr_write(8'h00, 32'h3, 4'h1);
    idle();
    csr_read(8'h08, d); check("clr_pkt_lo", 64'(d), 64'd0);
    csr_read(8'h0C, d); check("clr_pkt_hi", 64'(d), 64'd0);
    csr_read(8'h10, d); check("clr_byte_lo", 64'(d), 64'd0);
    csr_read(8'h18, d); check("clr_err", 64'(d), 64'd0);
    csr_read(8'h04, d); check("clr_status", 64'(d), 64'd0);
    csr_read(8'h24, d); check("clr_min", 64'(d), 64'hFFFF);
    csr_read(8'h00, d); check("ctrl_after_clr", 64'(d), 64'h1);

    csr_write(8'h00, 32'h0, 4'h1);
    pkt(16'd64, 1'b0, 1'b0);
    pkt(16'd64, 1'b0, 1'b1);
    csr_read(8'h08, d); check("pkt_cnt_disabled", 64'(d), 64'd0);
    csr_read(8'h1C, d); check("drop_cnt_disabled", 64'(d), 64'd0);

    csr_write(8'h28, 32'hAABB_CCDD, 4'h5);
    avmm_read_c1 = 1'b1; avmm_address_c1 = 8'h28;
    @(negedge clk);
    check("b2b_v0", 64'(avmm_readdatavalid), 64'd1);
    check("b2b_d0", 64'(avmm_readdata), 64'h00BB_00DD);
    avmm_address_c1 = 8'h30;
    @(negedge clk);
    check("b2b_v1", 64'(avmm_readdatavalid), 64'd1);
    check("b2b_d1", 64'(avmm_readdata), 64'h0);
    avmm_address_c1 = 8'h2C;
    @(negedge clk);
    avmm_read_c1 = 1'b0;
    check("b2b_v2", 64'(avmm_readdatavalid), 64'd1);
    check("b2b_d2", 64'(avmm_readdata), 64'hD8C0_0001);

    // Random traffic checked by the compare process.
    csr_write(8'h00, 32'h1, 4'h1);
    for (int c = 0; c < 600; c++) begin
      int r;
      r = $urandom_range(0, 99);
      avmm_read_c1      = (r < 45) || (r == 99);
      avmm_write_c1     = (r >= 45 && r < 60) || (r == 99);
      avmm_address_c1   = 8'($urandom);
      avmm_writedata_c1 = $urandom;
      avmm_byteenable_c1 = 4'($urandom);
      if (avmm_write_c1 && $urandom_range(0, 2) == 0) avmm_address_c1[5:2] = 4'h0;
      if (avmm_write_c1 && avmm_address_c1[5:2] == 4'h0) begin
        avmm_writedata_c1[0] = ($urandom_range(0, 4) != 0);
        avmm_writedata_c1[1] = ($urandom_range(0, 24) == 0);
      end
      rx_pkt_done = ($urandom_range(0, 2) == 0);
      rx_pkt_len  = ($urandom_range(0, 3) == 0) ? LEN_WIDTH'($urandom) : LEN_WIDTH'($urandom_range(40, 1600));
      rx_pkt_err  = ($urandom_range(0, 3) == 0);
      rx_pkt_drop = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_switch_rx_dbg_csr.md
Name: packet_switch_rx_dbg_csr

Overview:
Per-RX-port debug register file that sits directly downstream of the RX AVMM address-check stage. It consumes that stage's registered, region-qualified AVMM strobes and rebased local addresses, accumulates RX packet statistics from the packet-switch RX datapath, and returns read data with fixed latency. One instance exists per RX port, selected by INST_ID.

Parameters:
INST_ID, 0, RX port index; reported in the ID register.
ADDR_WIDTH, 8, local byte-address width; must match the upstream address-check stage.
DATA_WIDTH, 32, CSR data width; only 32 is supported.
LEN_WIDTH, 16, packet length field width in bytes.

Ports:
clk  in  1  clock
rst  in  1  Reset: synchronous, active-high (see Behaviour for what it clears).
avmm_address_c1  in  ADDR_WIDTH  Local byte address, already rebased to 0; word aligned.
avmm_read_c1  in  1  Read strobe; single-cycle, already region-qualified.
avmm_write_c1  in  1  Write strobe; single-cycle, already region-qualified.
avmm_writedata_c1  in  32  Write data.
avmm_byteenable_c1  in  4  Write byte enables.
avmm_readdata  out  32  Read data.
avmm_readdatavalid  out  1  Qualifies avmm_readdata.
rx_pkt_done  in  1  One-cycle pulse at end of each received packet.
rx_pkt_len  in  LEN_WIDTH  Packet length in bytes; valid with rx_pkt_done.
rx_pkt_err  in  1  Packet ended with error; valid with rx_pkt_done.
rx_pkt_drop  in  1  Packet dropped by switch; valid with rx_pkt_done.

Behaviour:
- Reset values:
  - avmm_readdatavalid = 0 and avmm_readdata = 0.
  - All counters = 0; MIN_LEN = all ones; MAX_LEN = 0; HI shadows = 0.
  - CTRL = 0x1 (counting enabled); SCRATCH = 0.
- Register map (byte offsets). Unused offsets 0x30–0x3C read 0; writes to them are ignored.
  - 0x00 CTRL (RW).
    - bit0 CNT_EN.
    - bit1 CLR: write-1 self-clearing; always reads 0.
  - 0x04 STATUS (RO).
    - bit0 ERR_SAT: ERR_CNT has saturated.
    - bit1 DROP_SAT: DROP_CNT has saturated.
  - 0x08 PKT_CNT_LO, 0x0C PKT_CNT_HI: 64-bit packet counter.
  - 0x10 BYTE_CNT_LO, 0x14 BYTE_CNT_HI: 64-bit byte counter.
  - 0x18 ERR_CNT: 32-bit, saturating.
  - 0x1C DROP_CNT: 32-bit, saturating.
  - 0x20 MAX_LEN (RO): zero-extended.
  - 0x24 MIN_LEN (RO): zero-extended.
  - 0x28 SCRATCH (RW): byteenable honoured.
  - 0x2C ID (RO): 0xD8C0_0000 | INST_ID[7:0].
- Address decode: uses avmm_address_c1[5:2]; bits [1:0] and bits above bit 5 are ignored.
- Read latency:
  - avmm_read_c1 in cycle N gives avmm_readdatavalid = 1 with data in cycle N+1, for exactly one cycle.
  - Every read returns data, including reads of unused offsets.
  - Back-to-back reads every cycle are supported.
- Write timing: takes effect at the clock edge ending cycle N. A read in cycle N+1 sees the new value.
- Byteenable:
  - Applies to CTRL bit0 (byte 0) and to SCRATCH.
  - CLR acts only when byteenable[0] = 1.
- 64-bit coherency:
  - Reading a LO word latches the matching HI word into a per-counter shadow in the same cycle.
  - Reading a HI word returns the shadow.
  - Reading HI without a preceding LO read returns the last shadow value.
- Statistics update, applied on rx_pkt_done when CNT_EN = 1:
  - PKT_CNT increments by 1.
  - BYTE_CNT increases by rx_pkt_len, zero-extended; 64-bit counters wrap modulo 2^64.
  - ERR_CNT increments if rx_pkt_err = 1; DROP_CNT increments if rx_pkt_drop = 1. Both saturate at 0xFFFF_FFFF and set their sticky STATUS bit.
  - MAX_LEN updates to max(MAX_LEN, len); MIN_LEN updates to min(MIN_LEN, len).
  - When CNT_EN = 0, all events are ignored.
- Clear (CLR write):
  - Counters, min/max, shadows and STATUS return to reset values on the same edge as the write.
  - CLR has priority over a simultaneous rx_pkt_done, which is lost.
  - CNT_EN takes the bit0 value written in the same access.
- Simultaneous read and event in one cycle: a LO read returns the pre-increment value. The shadow latches the pre-increment HI.
- Simultaneous read and write: cannot occur, since upstream strobes are exclusive. If both are asserted anyway, the write is performed and the read still returns the pre-write value.
- Reset mid-read: a read accepted in the reset cycle produces no readdatavalid.

Test Plan:
- Reset, then read ID with INST_ID = 1 → readdatavalid exactly 1 cycle later; data 0xD8C0_0001. Read CTRL → 0x1; MIN_LEN → 0xFFFF.
- Three rx_pkt_done pulses with lengths 64, 1518, 100 → PKT_CNT_LO = 3, BYTE_CNT_LO = 1682, MAX_LEN = 1518, MIN_LEN = 64.
- Preload BYTE_CNT to 0x0000_0000_FFFF_FFF0, add len 0x20 → LO = 0x10, HI = 0x1. Issue another event between the LO and HI reads → HI read still returns the shadow value 0x1.
- Drive ERR_CNT to 0xFFFF_FFFE, then 3 error packets → ERR_CNT = 0xFFFF_FFFF and STATUS = 0x1.
- Write CTRL = 0x3 (byteenable 0x1) in the same cycle as rx_pkt_done → all counters = 0 and CTRL reads 0x1. Then write CTRL = 0x0 and send 2 packets → PKT_CNT stays 0.
- Write SCRATCH = 0xAABBCCDD with byteenable 0x5 over an initial 0 → reads 0x00BB00DD. Back-to-back reads of 0x28, 0x30, 0x2C → three consecutive valid cycles with data 0x00BB00DD, 0x0, then the ID value.
